alu_op_sequencer: RTL and testbench

Issue-side controller for the datapath ALU: accepts operation requests over a valid/ready handshake, drives the ALU control bus and operand buses, and captures RESULT/FLAG. Holds the architectural NZCV status register, which supplies carry-in for ADC/SBC. Sequences 64-bit ADD64/SUB64 as two ALU passes with an internal carry. Returns each result over a second valid/ready handshake. Sits between instruction decode and the register-file write port.

---
 rtl/alu_op_sequencer_pkg.sv | 96 +++++++++
 rtl/alu_op_sequencer_ctrl_encode.sv | 36 +++
 rtl/alu_op_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcodes, ALU control-bus layout, FSM states and status helpers
// for the ALU operation sequencer.
package alu_op_sequencer_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADC   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SBC   = 5'd3;
    localparam logic [4:0] OP_RSB   = 5'd4;
    localparam logic [4:0] OP_AND   = 5'd5;
    localparam logic [4:0] OP_BIC   = 5'd6;
    localparam logic [4:0] OP_ORR   = 5'd7;
    localparam logic [4:0] OP_EOR   = 5'd8;
    localparam logic [4:0] OP_LSR   = 5'd9;
    localparam logic [4:0] OP_ASR   = 5'd10;
    localparam logic [4:0] OP_ROR   = 5'd11;
    localparam logic [4:0] OP_LSL   = 5'd12;
    localparam logic [4:0] OP_MOV   = 5'd13;
    localparam logic [4:0] OP_CMP   = 5'd14;
    localparam logic [4:0] OP_ADD64 = 5'd15;
    localparam logic [4:0] OP_SUB64 = 5'd16;

    localparam logic [2:0] SEL_ADD  = 3'd0;
    localparam logic [2:0] SEL_AND  = 3'd1;
    localparam logic [2:0] SEL_OR   = 3'd2;
    localparam logic [2:0] SEL_XOR  = 3'd3;
    localparam logic [2:0] SEL_SHR  = 3'd4;
    localparam logic [2:0] SEL_SHL  = 3'd5;
    localparam logic [2:0] SEL_PASS = 3'd6;
    localparam logic [2:0] SEL_ZERO = 3'd7;

    localparam logic [1:0] SH_LOGIC  = 2'b00;
    localparam logic [1:0] SH_ARITH  = 2'b01;
    localparam logic [1:0] SH_ROTATE = 2'b10;

    localparam int unsigned CTRL_SEL_LSB = 32'd0;
    localparam int unsigned CTRL_SH_LSB  = 32'd3;
    localparam int unsigned CTRL_CIN     = 32'd5;
    localparam int unsigned CTRL_RSB     = 32'd6;
    localparam int unsigned CTRL_SUB     = 32'd7;
    localparam int unsigned CTRL_INVB    = 32'd8;
    localparam logic [8:0]  CTRL_IDLE    = 9'h007;

    localparam int unsigned NZCV_N = 32'd3;
    localparam int unsigned NZCV_Z = 32'd2;
    localparam int unsigned NZCV_C = 32'd1;
    localparam int unsigned NZCV_V = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC_LO = 2'd1,
        ST_EXEC_HI = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    function automatic logic [8:0] make_ctrl(input logic [2:0] sel, input logic [1:0] sh,
                                             input logic cin, input logic rsb,
                                             input logic sub, input logic invb);
        logic [8:0] c;
        c = 9'h000;
        c[CTRL_SEL_LSB +: 3] = sel;
        c[CTRL_SH_LSB +: 2]  = sh;
        c[CTRL_CIN]          = cin;
        c[CTRL_RSB]          = rsb;
        c[CTRL_SUB]          = sub;
        c[CTRL_INVB]         = invb;
        return c;
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return (op <= OP_SUB64);
    endfunction

    function automatic logic is_wide(input logic [4:0] op);
        return (op == OP_ADD64) || (op == OP_SUB64);
    endfunction

    function automatic logic is_adder(input logic [4:0] op);
        return (op <= OP_RSB) || ((op >= OP_CMP) && (op <= OP_SUB64));
    endfunction

    // Logic, shift and move results leave C and V untouched.
    function automatic logic [3:0] nzcv_merge(input logic [4:0] op, input logic [3:0] old_flags,
                                              input logic [3:0] alu_flags);
        logic [3:0] f;
        f = old_flags;
        if (is_adder(op)) begin
            f = alu_flags;
        end else begin
            f[NZCV_N] = alu_flags[NZCV_N];
            f[NZCV_Z] = alu_flags[NZCV_Z];
        end
        return f;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_ctrl_encode.sv
// Combinational decode of opcode, pass and carry-in into the 9-bit ALU control bus.
module alu_ctrl_encode
    import alu_op_sequencer_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       pass_hi,
    input  logic       carry,
    output logic [8:0] ctrl
);

    // Opcode to control-bus field mapping; the high pass of a 64-bit op chains the low-pass carry
    always_comb begin
        ctrl = CTRL_IDLE;
        case (opcode)
            OP_ADD:   ctrl = make_ctrl(SEL_ADD,  SH_LOGIC,  1'b0,  1'b0, 1'b0, 1'b0);
            OP_ADC:   ctrl = make_ctrl(SEL_ADD,  SH_LOGIC,  carry, 1'b0, 1'b0, 1'b0);
            OP_SUB:   ctrl = make_ctrl(SEL_ADD,  SH_LOGIC,  1'b1,  1'b0, 1'b1, 1'b0);
            OP_SBC:   ctrl = make_ctrl(SEL_ADD,  SH_LOGIC,  carry, 1'b0, 1'b1, 1'b0);
            OP_RSB:   ctrl = make_ctrl(SEL_ADD,  SH_LOGIC,  1'b1,  1'b1, 1'b0, 1'b0);
            OP_AND:   ctrl = make_ctrl(SEL_AND,  SH_LOGIC,  1'b0,  1'b0, 1'b0, 1'b0);
            OP_BIC:   ctrl = make_ctrl(SEL_AND,  SH_LOGIC,  1'b0,  1'b0, 1'b0, 1'b1);
            OP_ORR:   ctrl = make_ctrl(SEL_OR,   SH_LOGIC,  1'b0,  1'b0, 1'b0, 1'b0);
            OP_EOR:   ctrl = make_ctrl(SEL_XOR,  SH_LOGIC,  1'b0,  1'b0, 1'b0, 1'b0);
            OP_LSR:   ctrl = make_ctrl(SEL_SHR,  SH_LOGIC,  1'b0,  1'b0, 1'b0, 1'b0);
            OP_ASR:   ctrl = make_ctrl(SEL_SHR,  SH_ARITH,  1'b0,  1'b0, 1'b0, 1'b0);
            OP_ROR:   ctrl = make_ctrl(SEL_SHR,  SH_ROTATE, 1'b0,  1'b0, 1'b0, 1'b0);
            OP_LSL:   ctrl = make_ctrl(SEL_SHL,  SH_LOGIC,  1'b0,  1'b0, 1'b0, 1'b0);
            OP_MOV:   ctrl = make_ctrl(SEL_PASS, SH_LOGIC,  1'b0,  1'b0, 1'b0, 1'b0);
            OP_CMP:   ctrl = make_ctrl(SEL_ADD,  SH_LOGIC,  1'b1,  1'b0, 1'b1, 1'b0);
            OP_ADD64: ctrl = make_ctrl(SEL_ADD,  SH_LOGIC,  pass_hi & carry, 1'b0, 1'b0, 1'b0);
            OP_SUB64: ctrl = make_ctrl(SEL_ADD,  SH_LOGIC,  pass_hi ? carry : 1'b1, 1'b0, 1'b1, 1'b0);
            default:  ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue-side ALU controller: request handshake, one or two ALU passes,
// NZCV status ownership and a held response until consumed.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             OP_VALID,
    output logic             OP_READY,
    input  logic [4:0]       OPCODE,
    input  logic             SET_FLAGS,
    input  logic [WIDTH-1:0] A_LO,
    input  logic [WIDTH-1:0] B_LO,
    input  logic [WIDTH-1:0] A_HI,
    input  logic [WIDTH-1:0] B_HI,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES_LO,
    output logic [WIDTH-1:0] RES_HI,
    output logic             RES_WE,
    output logic             RES_ERR,
    output logic [3:0]       NZCV,
    output logic [8:0]       ALU_CTRL_BUS,
    output logic [WIDTH-1:0] OP0_A_BUS,
    output logic [WIDTH-1:0] OP1_B_BUS,
    input  logic [WIDTH-1:0] ALU_RESULT,
    input  logic [3:0]       ALU_FLAG
);

    state_e           state_r, next_state_s;
    logic [4:0]       opcode_r;
    logic             set_flags_r;
    logic [WIDTH-1:0] a_hi_r, b_hi_r;
    logic             z_lo_r;
    logic             op_ready_r, res_valid_r, res_we_r, res_err_r;
    logic [WIDTH-1:0] res_lo_r, res_hi_r, op_a_r, op_b_r;
    logic [3:0]       nzcv_r, nzcv_nxt_s;
    logic [8:0]       ctrl_r, ctrl_nxt_s, enc_ctrl_s;
    logic [WIDTH-1:0] a_nxt_s, b_nxt_s;
    logic [4:0]       enc_op_s;
    logic             enc_hi_s, enc_carry_s;
    logic             accept_s, upd_flags_s, issue_lo_s, issue_hi_s;

    assign accept_s    = OP_VALID && (state_r == ST_IDLE);
    assign upd_flags_s = set_flags_r || (opcode_r == OP_CMP);
    assign issue_lo_s  = accept_s && is_legal(OPCODE);
    assign issue_hi_s  = (state_r == ST_EXEC_LO) && is_wide(opcode_r);

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = is_legal(OPCODE) ? ST_EXEC_LO : ST_RESP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC_LO: next_state_s = is_wide(opcode_r) ? ST_EXEC_HI : ST_RESP;
            ST_EXEC_HI: next_state_s = ST_RESP;
            ST_RESP: begin
                if (RES_READY) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Encoder inputs for the pass that starts on the coming edge
    always_comb begin
        enc_op_s    = opcode_r;
        enc_hi_s    = 1'b0;
        enc_carry_s = nzcv_r[NZCV_C];
        if (issue_lo_s) begin
            enc_op_s = OPCODE;
        end else if (issue_hi_s) begin
            enc_hi_s    = 1'b1;
            enc_carry_s = ALU_FLAG[NZCV_C];
        end else begin
            enc_op_s = opcode_r;
        end
    end

    alu_ctrl_encode u_encode (
        .opcode  (enc_op_s),
        .pass_hi (enc_hi_s),
        .carry   (enc_carry_s),
        .ctrl    (enc_ctrl_s)
    );

    // ALU bus values for the next cycle; parked outside the EXEC states
    always_comb begin
        ctrl_nxt_s = CTRL_IDLE;
        a_nxt_s    = {WIDTH{1'b0}};
        b_nxt_s    = {WIDTH{1'b0}};
        if (issue_lo_s) begin
            ctrl_nxt_s = enc_ctrl_s;
            a_nxt_s    = A_LO;
            b_nxt_s    = B_LO;
        end else if (issue_hi_s) begin
            ctrl_nxt_s = enc_ctrl_s;
            a_nxt_s    = a_hi_r;
            b_nxt_s    = b_hi_r;
        end else begin
            ctrl_nxt_s = CTRL_IDLE;
        end
    end

    // Status commit in the final EXEC cycle; 64-bit Z spans both halves
    always_comb begin
        nzcv_nxt_s = nzcv_r;
        if ((state_r == ST_EXEC_LO) && !is_wide(opcode_r) && upd_flags_s) begin
            nzcv_nxt_s = nzcv_merge(opcode_r, nzcv_r, ALU_FLAG);
        end else if ((state_r == ST_EXEC_HI) && upd_flags_s) begin
            nzcv_nxt_s = nzcv_merge(opcode_r, nzcv_r,
                                    {ALU_FLAG[NZCV_N], z_lo_r & ALU_FLAG[NZCV_Z],
                                     ALU_FLAG[NZCV_C], ALU_FLAG[NZCV_V]});
        end else begin
            nzcv_nxt_s = nzcv_r;
        end
    end

    // Sequencer, operand latch, result capture and output registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            opcode_r    <= 5'd0;
            set_flags_r <= 1'b0;
            a_hi_r      <= {WIDTH{1'b0}};
            b_hi_r      <= {WIDTH{1'b0}};
            z_lo_r      <= 1'b0;
            op_ready_r  <= 1'b1;
            res_valid_r <= 1'b0;
            res_we_r    <= 1'b0;
            res_err_r   <= 1'b0;
            res_lo_r    <= {WIDTH{1'b0}};
            res_hi_r    <= {WIDTH{1'b0}};
            nzcv_r      <= 4'b0000;
            ctrl_r      <= CTRL_IDLE;
            op_a_r      <= {WIDTH{1'b0}};
            op_b_r      <= {WIDTH{1'b0}};
        end else begin
            state_r     <= next_state_s;
            op_ready_r  <= (next_state_s == ST_IDLE);
            res_valid_r <= (next_state_s == ST_RESP);
            ctrl_r      <= ctrl_nxt_s;
            op_a_r      <= a_nxt_s;
            op_b_r      <= b_nxt_s;
            nzcv_r      <= nzcv_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        opcode_r    <= OPCODE;
                        set_flags_r <= SET_FLAGS;
                        a_hi_r      <= A_HI;
                        b_hi_r      <= B_HI;
                        res_we_r    <= is_legal(OPCODE) && (OPCODE != OP_CMP);
                        res_err_r   <= !is_legal(OPCODE);
                        res_lo_r    <= {WIDTH{1'b0}};
                        res_hi_r    <= {WIDTH{1'b0}};
                    end
                end
                ST_EXEC_LO: begin
                    res_lo_r <= ALU_RESULT;
                    z_lo_r   <= ALU_FLAG[NZCV_Z];
                end
                ST_EXEC_HI: res_hi_r <= ALU_RESULT;
                default: ;
            endcase
        end
    end

    assign OP_READY     = op_ready_r;
    assign RES_VALID    = res_valid_r;
    assign RES_LO       = res_lo_r;
    assign RES_HI       = res_hi_r;
    assign RES_WE       = res_we_r;
    assign RES_ERR      = res_err_r;
    assign NZCV         = nzcv_r;
    assign ALU_CTRL_BUS = ctrl_r;
    assign OP0_A_BUS    = op_a_r;
    assign OP1_B_BUS    = op_b_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural downstream ALU.
module tb_alu_op_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N, OP_VALID, OP_READY, SET_FLAGS, RES_VALID, RES_READY, RES_WE, RES_ERR;
    logic [4:0]  OPCODE;
    logic [31:0] A_LO, B_LO, A_HI, B_HI, RES_LO, RES_HI, OP0_A_BUS, OP1_B_BUS, ALU_RESULT;
    logic [3:0]  NZCV, ALU_FLAG;
    logic [8:0]  ALU_CTRL_BUS;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    alu_op_sequencer #(.WIDTH(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
        .OPCODE(OPCODE), .SET_FLAGS(SET_FLAGS), .A_LO(A_LO), .B_LO(B_LO),
        .A_HI(A_HI), .B_HI(B_HI), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_LO(RES_LO), .RES_HI(RES_HI), .RES_WE(RES_WE), .RES_ERR(RES_ERR),
        .NZCV(NZCV), .ALU_CTRL_BUS(ALU_CTRL_BUS), .OP0_A_BUS(OP0_A_BUS),
        .OP1_B_BUS(OP1_B_BUS), .ALU_RESULT(ALU_RESULT), .ALU_FLAG(ALU_FLAG)
    );

    // Downstream ALU model driven by the control bus
    logic [31:0] m_a, m_b;
    logic [32:0] m_sum;
    logic [63:0] m_rot;
    logic [4:0]  m_sh;
    logic        m_c, m_v;
    always_comb begin
        m_a = ALU_CTRL_BUS[6] ? ~OP0_A_BUS : OP0_A_BUS;
        m_b = ALU_CTRL_BUS[7] ? ~OP1_B_BUS : OP1_B_BUS;
        m_sum = {1'b0, m_a} + {1'b0, m_b} + {32'd0, ALU_CTRL_BUS[5]};
        m_sh = OP1_B_BUS[4:0];
        m_rot = {OP0_A_BUS, OP0_A_BUS} >> m_sh;
        m_c = 1'b0;
        m_v = 1'b0;
        ALU_RESULT = 32'd0;
        case (ALU_CTRL_BUS[2:0])
            3'd0: begin
                ALU_RESULT = m_sum[31:0];
                m_c = m_sum[32];
                m_v = (m_a[31] == m_b[31]) && (m_sum[31] != m_a[31]);
            end
            3'd1: ALU_RESULT = OP0_A_BUS & (ALU_CTRL_BUS[8] ? ~OP1_B_BUS : OP1_B_BUS);
            3'd2: ALU_RESULT = OP0_A_BUS | OP1_B_BUS;
            3'd3: ALU_RESULT = OP0_A_BUS ^ OP1_B_BUS;
            3'd4: begin
                case (ALU_CTRL_BUS[4:3])
                    2'b01:   ALU_RESULT = $unsigned($signed(OP0_A_BUS) >>> m_sh);
                    2'b10:   ALU_RESULT = m_rot[31:0];
                    default: ALU_RESULT = OP0_A_BUS >> m_sh;
                endcase
            end
            3'd5: ALU_RESULT = OP0_A_BUS << m_sh;
            3'd6: ALU_RESULT = OP1_B_BUS;
            default: ALU_RESULT = 32'd0;
        endcase
        ALU_FLAG = {ALU_RESULT[31], (ALU_RESULT == 32'd0), m_c, m_v};
    end

    typedef struct {
        logic [4:0]  op;
        logic        sf;
        logic [31:0] alo, blo, ahi, bhi;
        logic [8:0]  ctrl;
        logic [31:0] rlo, rhi;
        logic        we, err;
        logic [3:0]  nzcv;
        int          lat;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " op_ready"}, {63'd0, OP_READY}, 64'd1);
        chk({tag, " res_valid"}, {63'd0, RES_VALID}, 64'd0);
        chk({tag, " res_we"}, {63'd0, RES_WE}, 64'd0);
        chk({tag, " res_err"}, {63'd0, RES_ERR}, 64'd0);
        chk({tag, " res"}, {RES_HI, RES_LO}, 64'd0);
        chk({tag, " nzcv"}, {60'd0, NZCV}, 64'd0);
        chk({tag, " ctrl"}, {55'd0, ALU_CTRL_BUS}, 64'h007);
        chk({tag, " buses"}, {OP0_A_BUS, OP1_B_BUS}, 64'd0);
    endtask

    task automatic present(input logic [4:0] op, input logic sf, input logic [31:0] alo,
                           input logic [31:0] blo, input logic [31:0] ahi, input logic [31:0] bhi);
        OPCODE = op; SET_FLAGS = sf; A_LO = alo; B_LO = blo; A_HI = ahi; B_HI = bhi;
        OP_VALID = 1'b1;
    endtask

    // Latency counts the request cycle as cycle 0.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge CLK);
        present(v.op, v.sf, v.alo, v.blo, v.ahi, v.bhi);
        chk($sformatf("v%0d op_ready", idx), {63'd0, OP_READY}, 64'd1);
        @(posedge CLK); #1;
        OP_VALID = 1'b0;
        chk($sformatf("v%0d ctrl", idx), {55'd0, ALU_CTRL_BUS}, {55'd0, v.ctrl});
        lat = 1;
        while (!RES_VALID && lat < 8) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d result", idx), {RES_HI, RES_LO}, {v.rhi, v.rlo});
        chk($sformatf("v%0d we/err", idx), {62'd0, RES_WE, RES_ERR}, {62'd0, v.we, v.err});
        chk($sformatf("v%0d nzcv", idx), {60'd0, NZCV}, {60'd0, v.nzcv});
        RES_READY = 1'b1;
        @(posedge CLK); #1;
        RES_READY = 1'b0;
        chk($sformatf("v%0d valid drop", idx), {63'd0, RES_VALID}, 64'd0);
    endtask

    task automatic stall_chk(input string tag, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] rlo, input logic we,
                             input logic err, input logic [3:0] nzcv);
        int wait_c;
        @(negedge CLK);
        present(op, 1'b0, a, b, 32'd0, 32'd0);
        @(posedge CLK); #1;
        OP_VALID = 1'b0;
        wait_c = 0;
        while (!RES_VALID && wait_c < 8) begin
            @(posedge CLK); #1;
            wait_c++;
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s hold%0d valid/ready", tag, i), {62'd0, RES_VALID, OP_READY}, 64'd2);
            chk($sformatf("%s hold%0d result", tag, i), {RES_HI, RES_LO}, {32'd0, rlo});
            chk($sformatf("%s hold%0d flags", tag, i), {58'd0, RES_WE, RES_ERR, NZCV},
                {58'd0, we, err, nzcv});
            @(posedge CLK); #1;
        end
        RES_READY = 1'b1;
        @(posedge CLK); #1;
        RES_READY = 1'b0;
    endtask

    initial begin
        int accepts, overlap, late_valid;
        RST_N = 1'b0; OP_VALID = 1'b0; RES_READY = 1'b0;
        OPCODE = 5'd0; SET_FLAGS = 1'b0;
        A_LO = 32'd0; B_LO = 32'd0; A_HI = 32'd0; B_HI = 32'd0;

        //          op     sf    a_lo          b_lo          a_hi          b_hi          ctrl    res_lo        res_hi        we    err   nzcv     lat
        vecs[0]  = '{5'd0,  1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        9'h000, 32'h00000000, 32'h0,        1'b1, 1'b0, 4'b0110, 2};
        vecs[1]  = '{5'd15, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        9'h000, 32'h00000000, 32'h1,        1'b1, 1'b0, 4'b0000, 3};
        vecs[2]  = '{5'd14, 1'b0, 32'h00000005, 32'h00000005, 32'h0,        32'h0,        9'h0A0, 32'h00000000, 32'h0,        1'b0, 1'b0, 4'b0110, 2};
        vecs[3]  = '{5'd3,  1'b0, 32'h0000000A, 32'h00000003, 32'h0,        32'h0,        9'h0A0, 32'h00000007, 32'h0,        1'b1, 1'b0, 4'b0110, 2};
        vecs[4]  = '{5'd7,  1'b1, 32'h80000000, 32'h00000000, 32'h0,        32'h0,        9'h002, 32'h80000000, 32'h0,        1'b1, 1'b0, 4'b1010, 2};
        vecs[5]  = '{5'd1,  1'b1, 32'h00000001, 32'h00000002, 32'h0,        32'h0,        9'h020, 32'h00000004, 32'h0,        1'b1, 1'b0, 4'b0000, 2};
        vecs[6]  = '{5'd1,  1'b0, 32'h00000001, 32'h00000002, 32'h0,        32'h0,        9'h000, 32'h00000003, 32'h0,        1'b1, 1'b0, 4'b0000, 2};
        vecs[7]  = '{5'd2,  1'b1, 32'h00000003, 32'h00000005, 32'h0,        32'h0,        9'h0A0, 32'hFFFFFFFE, 32'h0,        1'b1, 1'b0, 4'b1000, 2};
        vecs[8]  = '{5'd4,  1'b1, 32'h00000003, 32'h00000005, 32'h0,        32'h0,        9'h060, 32'h00000002, 32'h0,        1'b1, 1'b0, 4'b0010, 2};
        vecs[9]  = '{5'd5,  1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h0,        32'h0,        9'h001, 32'h0000F000, 32'h0,        1'b1, 1'b0, 4'b0010, 2};
        vecs[10] = '{5'd6,  1'b1, 32'h0000F0F0, 32'h0000FF00, 32'h0,        32'h0,        9'h101, 32'h000000F0, 32'h0,        1'b1, 1'b0, 4'b0010, 2};
        vecs[11] = '{5'd8,  1'b1, 32'h000000FF, 32'h000000FF, 32'h0,        32'h0,        9'h003, 32'h00000000, 32'h0,        1'b1, 1'b0, 4'b0110, 2};
        vecs[12] = '{5'd9,  1'b0, 32'h80000000, 32'h00000004, 32'h0,        32'h0,        9'h004, 32'h08000000, 32'h0,        1'b1, 1'b0, 4'b0110, 2};
        vecs[13] = '{5'd10, 1'b1, 32'h80000000, 32'h00000004, 32'h0,        32'h0,        9'h00C, 32'hF8000000, 32'h0,        1'b1, 1'b0, 4'b1010, 2};
        vecs[14] = '{5'd11, 1'b0, 32'h00000001, 32'h00000001, 32'h0,        32'h0,        9'h014, 32'h80000000, 32'h0,        1'b1, 1'b0, 4'b1010, 2};
        vecs[15] = '{5'd12, 1'b0, 32'h00000001, 32'h0000001F, 32'h0,        32'h0,        9'h005, 32'h80000000, 32'h0,        1'b1, 1'b0, 4'b1010, 2};
        vecs[16] = '{5'd13, 1'b1, 32'h00001234, 32'h00000000, 32'h0,        32'h0,        9'h006, 32'h00000000, 32'h0,        1'b1, 1'b0, 4'b0110, 2};
        vecs[17] = '{5'd16, 1'b1, 32'h00000000, 32'h00000001, 32'h00000001, 32'h00000000, 9'h0A0, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 4'b0010, 3};
        vecs[18] = '{5'd0,  1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h0,        9'h000, 32'h80000000, 32'h0,        1'b1, 1'b0, 4'b1001, 2};
        vecs[19] = '{5'd20, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h0,        32'h0,        9'h007, 32'h00000000, 32'h0,        1'b0, 1'b1, 4'b1001, 1};
        vecs[20] = '{5'd15, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 9'h000, 32'h00000000, 32'h0,        1'b1, 1'b0, 4'b1001, 3};

        repeat (2) @(posedge CLK);
        #1;
        check_reset("reset");
        RST_N = 1'b1;

        for (int i = 0; i < 21; i++) begin
            run_vec(vecs[i], i);
        end

        // Response held with RES_READY low for five cycles.
        stall_chk("add_stall", 5'd0, 32'd2, 32'd3, 32'd5, 1'b1, 1'b0, 4'b1001);
        stall_chk("ill_stall", 5'd20, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 4'b1001);

        // Back-to-back requests with RES_READY tied high.
        @(negedge CLK);
        present(5'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0);
        RES_READY = 1'b1;
        accepts = 0;
        overlap = 0;
        for (int c = 0; c < 9; c++) begin
            if (OP_VALID && OP_READY) accepts++;
            if (OP_VALID && OP_READY && RES_VALID && RES_READY) overlap++;
            @(negedge CLK);
        end
        OP_VALID = 1'b0;
        RES_READY = 1'b0;
        chk("throughput accepts", 64'(accepts), 64'd3);
        chk("throughput overlap", 64'(overlap), 64'd0);
        chk("throughput result", {RES_HI, RES_LO}, 64'd2);

        // Reset asserted during the high pass of SUB64.
        @(negedge CLK);
        present(5'd16, 1'b1, 32'd0, 32'd1, 32'd1, 32'd0);
        @(posedge CLK); #1;
        OP_VALID = 1'b0;
        @(posedge CLK); #1;
        chk("rst_mid hi pass ctrl", {55'd0, ALU_CTRL_BUS}, 64'h080);
        RST_N = 1'b0;
        @(posedge CLK); #1;
        check_reset("rst_mid");
        RST_N = 1'b1;
        late_valid = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            if (RES_VALID) late_valid++;
        end
        chk("rst_mid no response", 64'(late_valid), 64'd0);
        chk("rst_mid nzcv", {60'd0, NZCV}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
